vip_config_responder: RTL and testbench
=======================================

Name: vip_config_responder

Overview:
- Avalon-MM write-only responder for the 9-bit video-config register map (scaler 0x000–0x07F, mixer 0x080–0x0FF, video mode 0x100–0x1FF).
- Holds a shadow and an active register set per group. A "Go" write arms a commit, and the commit takes effect on the next frame boundary.
- Drives lightweight scaler/mixer/CVO logic in place of the vendor IP.
- Also serves as the behavioural target for config-master verification.

Parameters:
- WAIT_CYCLES, 2, waitrequest-high cycles after each accepted write (0 = no stall).
- DEF_WIDTH, 1280, reset value of all active/shadow widths.
- DEF_HEIGHT, 720, reset value of all active/shadow heights.
- DEF_HFP, 110; DEF_HS, 40; DEF_HBL, 370; DEF_VFP, 5; DEF_VS, 5; DEF_VBL, 30: reset timing values.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- address  in  9  word address
- write  in  1  write request, held until accepted
- writedata  in  32  write data
- waitrequest  out  1  stall; a write is accepted in the cycle where write=1 and waitrequest=0
- frame_start  in  1  one-cycle pulse at output frame boundary
- scl_w, scl_h  out  12 each  active scaler output size
- mix_bkg_w, mix_bkg_h, mix_pos_x, mix_pos_y  out  12 each  active mixer geometry
- mix_en  out  1  video layer 0 enable
- cvo_hact, cvo_vact, cvo_hfp, cvo_hs, cvo_hbl, cvo_vfp, cvo_vs, cvo_vbl  out  12 each  active timing
- cvo_interlaced  out  1  active scan mode
- cfg_update  out  3  one-cycle pulse per group committed {cvo, mix, scl}

Behaviour:
Reset values
- waitrequest=1 while reset is asserted; it falls on the first clk after release.
- All active and shadow registers take their DEF_* values.
- mix_pos_x = mix_pos_y = 0; mix_en = 0; cvo_interlaced = 0; cvo valid = 0.
- All pending flags = 0; cfg_update = 0.

Write handshake
- On accept, the write decodes into shadow registers in the same edge.
- If WAIT_CYCLES>0, waitrequest is then held high for exactly WAIT_CYCLES cycles by a down-counter. Back-to-back writes are therefore spaced WAIT_CYCLES+1 cycles apart.
- write=1 with waitrequest=1: no effect; the master holds its request.

Address decode (shadow writes, writedata[11:0], upper bits discarded)
- Scaler: 0x003 width, 0x004 height, 0x000 Go.
- Mixer: 0x083 bkg width, 0x084 bkg height, 0x088 pos X, 0x089 pos Y, 0x08A enable (bit0), 0x080 Go.
- Video mode:
  - 0x104 bank: accepted, ignored.
  - 0x105 interlaced (bit0).
  - 0x106 hact, 0x107 vact, 0x109 hfp, 0x10A hs, 0x10B hbl, 0x10C vfp, 0x10D vs, 0x10E vbl.
  - 0x11E valid (bit0).
  - 0x100 Go.
- Unmapped addresses are acknowledged normally and discarded.

Go and commit
- A Go write with bit0=1 sets that group's pending flag. Go with bit0=0 clears it.
- On frame_start, each group with pending=1 copies shadow to active, clears pending, and pulses its cfg_update bit in the next cycle.
- CVO group commits only if shadow valid=1. If valid=0, pending stays set.

Simultaneous events
- A write accepted in the same cycle as frame_start lands in shadow after the commit; the commit uses the pre-write shadow.
- A Go accepted in the same cycle as frame_start sets pending for the following frame_start.

Other boundaries
- Repeated Go before frame_start behaves as a single commit.
- Reset mid-sequence discards all shadow, pending and active state.

Optional Feature:
- Macro: VIP_CFG_READBACK_EN.
- With the macro defined:
  - Adds ports read (in, 1), readdata (out, 32) and readdatavalid (out, 1).
  - An accepted read returns the shadow value of a mapped address zero-extended, or 0 for unmapped, with readdatavalid one cycle after accept.
  - Go addresses return {31'b0, pending}.
  - Reads use the same waitrequest stall as writes.
  - read and write asserted together: write wins, and the read stays pending.
- Without the macro: no read ports; logic is write-only.

Decomposition:
- Package vip_cfg_pkg holds:
  - localparam address constants for every register above.
  - Group index constants SCL=0, MIX=1, CVO=2.
  - Packed structs scl_cfg_t, mix_cfg_t, cvo_cfg_t.
- One sub-module, vip_cfg_bank: parameterised by struct width; holds shadow, active and pending; inputs wr_en, wr_value, go, go_val, frame_start, commit_ok; outputs active and update pulse. Instantiated three times.

Test Plan:
1. Reset release, then write 0x003=960 and 0x000=1, then frame_start → waitrequest 1 until first clk after reset. scl_w stays 1280 until frame_start. scl_w=960 and cfg_update=3'b001 one cycle after.
2. WAIT_CYCLES=2, two writes presented back-to-back → second write accepted exactly 3 cycles after the first; waitrequest high 2 cycles after each accept.
3. Write CVO fields with 0x11E=0, Go 0x100=1, frame_start → cvo_hact unchanged, pending held. Then write 0x11E=1, frame_start → commit, cfg_update=3'b100.
4. Write 0x088=160 accepted in the same cycle as frame_start with mix pending → active mix_pos_x keeps old value; next Go plus frame_start → 160.
5. Write 0x1FF=0xDEAD and 0x083=0x1500 → no visible change from 0x1FF. After Go plus frame_start, mix_bkg_w=0x500 (truncated).
6. Assert reset mid-sequence after shadow writes and Go → all outputs return to DEF_* values; no cfg_update on the next frame_start.

Source files
------------

// File: rtl/vip_cfg_pkg.sv
// ============================================================================
// vip_cfg_pkg: register map, group indices and config structs (VIP_CFG_READBACK_EN aware)
// Rev 1.0
// ============================================================================
`default_nettype none

package vip_cfg_pkg;

   localparam logic [8:0] ADDR_SCL_GO    = 9'h000;
   localparam logic [8:0] ADDR_SCL_W     = 9'h003;
   localparam logic [8:0] ADDR_SCL_H     = 9'h004;
   localparam logic [8:0] ADDR_MIX_GO    = 9'h080;
   localparam logic [8:0] ADDR_MIX_BKG_W = 9'h083;
   localparam logic [8:0] ADDR_MIX_BKG_H = 9'h084;
   localparam logic [8:0] ADDR_MIX_POS_X = 9'h088;
   localparam logic [8:0] ADDR_MIX_POS_Y = 9'h089;
   localparam logic [8:0] ADDR_MIX_EN    = 9'h08A;
   localparam logic [8:0] ADDR_CVO_GO    = 9'h100;
   localparam logic [8:0] ADDR_CVO_BANK  = 9'h104;
   localparam logic [8:0] ADDR_CVO_IL    = 9'h105;
   localparam logic [8:0] ADDR_CVO_HACT  = 9'h106;
   localparam logic [8:0] ADDR_CVO_VACT  = 9'h107;
   localparam logic [8:0] ADDR_CVO_HFP   = 9'h109;
   localparam logic [8:0] ADDR_CVO_HS    = 9'h10A;
   localparam logic [8:0] ADDR_CVO_HBL   = 9'h10B;
   localparam logic [8:0] ADDR_CVO_VFP   = 9'h10C;
   localparam logic [8:0] ADDR_CVO_VS    = 9'h10D;
   localparam logic [8:0] ADDR_CVO_VBL   = 9'h10E;
   localparam logic [8:0] ADDR_CVO_VALID = 9'h11E;

   localparam int SCL = 0;
   localparam int MIX = 1;
   localparam int CVO = 2;

   typedef struct packed {
      logic [11:0] w;
      logic [11:0] h;
   } scl_cfg_t;

   typedef struct packed {
      logic [11:0] bkg_w;
      logic [11:0] bkg_h;
      logic [11:0] pos_x;
      logic [11:0] pos_y;
      logic        en;
   } mix_cfg_t;

   typedef struct packed {
      logic [11:0] hact;
      logic [11:0] vact;
      logic [11:0] hfp;
      logic [11:0] hs;
      logic [11:0] hbl;
      logic [11:0] vfp;
      logic [11:0] vs;
      logic [11:0] vbl;
      logic        interlaced;
   } cvo_cfg_t;

   function automatic logic [31:0] zext12(input logic [11:0] v);
      return {20'b0, v};
   endfunction

endpackage

`default_nettype wire

// File: rtl/vip_cfg_bank.sv
// ============================================================================
// vip_cfg_bank: shadow/active register pair with frame-synchronous commit (VIP_CFG_READBACK_EN exposes pending)
// Rev 1.0
// ============================================================================
`default_nettype none

module vip_cfg_bank
   import vip_cfg_pkg::*;
#(
   parameter int             W         = 1,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_value,
   input  logic         go,
   input  logic         go_val,
   input  logic         frame_start,
   input  logic         commit_ok,
   output logic [W-1:0] shadow,
   output logic [W-1:0] active,
   output logic         update
`ifdef VIP_CFG_READBACK_EN
   ,
   output logic         pending
`endif
);

   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] active_q, active_d;
   logic         pending_q, pending_d;
   logic         update_q, update_d;
   logic         commit;

   // Commit samples the pre-write shadow, so a same-edge write lands after it.
   always_comb begin
      commit    = frame_start & pending_q & commit_ok;
      shadow_d  = wr_en ? wr_value : shadow_q;
      active_d  = commit ? shadow_q : active_q;
      update_d  = commit;
      pending_d = pending_q;
      if (go) begin
         pending_d = go_val;
      end else if (commit) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q  <= RESET_VAL;
         active_q  <= RESET_VAL;
         pending_q <= 1'b0;
         update_q  <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         update_q  <= update_d;
      end
   end

   assign shadow = shadow_q;
   assign active = active_q;
   assign update = update_q;
`ifdef VIP_CFG_READBACK_EN
   assign pending = pending_q;
`endif

endmodule

`default_nettype wire

// File: rtl/vip_config_responder.sv
// ============================================================================
// vip_config_responder: Avalon-MM video-config responder; VIP_CFG_READBACK_EN adds a read port
// Rev 1.0
// ============================================================================
`default_nettype none

module vip_config_responder
   import vip_cfg_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEF_WIDTH   = 1280,
   parameter int DEF_HEIGHT  = 720,
   parameter int DEF_HFP     = 110,
   parameter int DEF_HS      = 40,
   parameter int DEF_HBL     = 370,
   parameter int DEF_VFP     = 5,
   parameter int DEF_VS      = 5,
   parameter int DEF_VBL     = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  address,
   input  logic        write,
   input  logic [31:0] writedata,
`ifdef VIP_CFG_READBACK_EN
   input  logic        read,
   output logic [31:0] readdata,
   output logic        readdatavalid,
`endif
   output logic        waitrequest,
   input  logic        frame_start,
   output logic [11:0] scl_w,
   output logic [11:0] scl_h,
   output logic [11:0] mix_bkg_w,
   output logic [11:0] mix_bkg_h,
   output logic [11:0] mix_pos_x,
   output logic [11:0] mix_pos_y,
   output logic        mix_en,
   output logic [11:0] cvo_hact,
   output logic [11:0] cvo_vact,
   output logic [11:0] cvo_hfp,
   output logic [11:0] cvo_hs,
   output logic [11:0] cvo_hbl,
   output logic [11:0] cvo_vfp,
   output logic [11:0] cvo_vs,
   output logic [11:0] cvo_vbl,
   output logic        cvo_interlaced,
   output logic [2:0]  cfg_update
);

   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   localparam scl_cfg_t SCL_RST = '{w: 12'(DEF_WIDTH), h: 12'(DEF_HEIGHT)};
   localparam mix_cfg_t MIX_RST = '{bkg_w: 12'(DEF_WIDTH), bkg_h: 12'(DEF_HEIGHT),
                                    pos_x: 12'd0, pos_y: 12'd0, en: 1'b0};
   localparam cvo_cfg_t CVO_RST = '{hact: 12'(DEF_WIDTH), vact: 12'(DEF_HEIGHT),
                                    hfp: 12'(DEF_HFP), hs: 12'(DEF_HS), hbl: 12'(DEF_HBL),
                                    vfp: 12'(DEF_VFP), vs: 12'(DEF_VS), vbl: 12'(DEF_VBL),
                                    interlaced: 1'b0};

   logic            wait_q, wait_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_accept, rd_accept, accept;
   logic            cvo_valid_q, cvo_valid_d;
   logic [11:0]     wd12;
   logic            unused_wdata;
   scl_cfg_t        scl_sh, scl_new, scl_act;
   mix_cfg_t        mix_sh, mix_new, mix_act;
   cvo_cfg_t        cvo_sh, cvo_new, cvo_act;
   logic [2:0]      hit, go, upd;
   logic [2:0]      pend;

   assign wd12         = writedata[11:0];
   assign unused_wdata = ^writedata[31:12];
   assign wr_accept    = write & ~wait_q;
   assign accept       = wr_accept | rd_accept;

   // Stall counter: waitrequest stays high for WAIT_CYCLES after each accept.
   always_comb begin
      wait_d = 1'b0;
      cnt_d  = cnt_q;
      if (accept && (WAIT_CYCLES > 0)) begin
         wait_d = 1'b1;
         cnt_d  = CNT_LOAD;
      end else if (cnt_q != '0) begin
         wait_d = 1'b1;
         cnt_d  = cnt_q - CW'(1);
      end
   end

   always_comb begin
      scl_new     = scl_sh;
      mix_new     = mix_sh;
      cvo_new     = cvo_sh;
      hit         = 3'b000;
      go          = 3'b000;
      cvo_valid_d = cvo_valid_q;
      case (address)
         ADDR_SCL_GO:    go[SCL] = wr_accept;
         ADDR_SCL_W:     begin scl_new.w = wd12;     hit[SCL] = 1'b1; end
         ADDR_SCL_H:     begin scl_new.h = wd12;     hit[SCL] = 1'b1; end
         ADDR_MIX_GO:    go[MIX] = wr_accept;
         ADDR_MIX_BKG_W: begin mix_new.bkg_w = wd12; hit[MIX] = 1'b1; end
         ADDR_MIX_BKG_H: begin mix_new.bkg_h = wd12; hit[MIX] = 1'b1; end
         ADDR_MIX_POS_X: begin mix_new.pos_x = wd12; hit[MIX] = 1'b1; end
         ADDR_MIX_POS_Y: begin mix_new.pos_y = wd12; hit[MIX] = 1'b1; end
         ADDR_MIX_EN:    begin mix_new.en = writedata[0]; hit[MIX] = 1'b1; end
         ADDR_CVO_GO:    go[CVO] = wr_accept;
         ADDR_CVO_IL:    begin cvo_new.interlaced = writedata[0]; hit[CVO] = 1'b1; end
         ADDR_CVO_HACT:  begin cvo_new.hact = wd12;  hit[CVO] = 1'b1; end
         ADDR_CVO_VACT:  begin cvo_new.vact = wd12;  hit[CVO] = 1'b1; end
         ADDR_CVO_HFP:   begin cvo_new.hfp = wd12;   hit[CVO] = 1'b1; end
         ADDR_CVO_HS:    begin cvo_new.hs = wd12;    hit[CVO] = 1'b1; end
         ADDR_CVO_HBL:   begin cvo_new.hbl = wd12;   hit[CVO] = 1'b1; end
         ADDR_CVO_VFP:   begin cvo_new.vfp = wd12;   hit[CVO] = 1'b1; end
         ADDR_CVO_VS:    begin cvo_new.vs = wd12;    hit[CVO] = 1'b1; end
         ADDR_CVO_VBL:   begin cvo_new.vbl = wd12;   hit[CVO] = 1'b1; end
         ADDR_CVO_VALID: if (wr_accept) cvo_valid_d = writedata[0];
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_q      <= 1'b1;
         cnt_q       <= '0;
         cvo_valid_q <= 1'b0;
      end else begin
         wait_q      <= wait_d;
         cnt_q       <= cnt_d;
         cvo_valid_q <= cvo_valid_d;
      end
   end

   vip_cfg_bank #(.W($bits(scl_cfg_t)), .RESET_VAL(SCL_RST)) u_scl_bank (
      .clk(clk), .reset(reset), .wr_en(wr_accept & hit[SCL]), .wr_value(scl_new),
      .go(go[SCL]), .go_val(writedata[0]), .frame_start(frame_start), .commit_ok(1'b1),
      .shadow(scl_sh), .active(scl_act), .update(upd[SCL])
`ifdef VIP_CFG_READBACK_EN
      , .pending(pend[SCL])
`endif
   );

   vip_cfg_bank #(.W($bits(mix_cfg_t)), .RESET_VAL(MIX_RST)) u_mix_bank (
      .clk(clk), .reset(reset), .wr_en(wr_accept & hit[MIX]), .wr_value(mix_new),
      .go(go[MIX]), .go_val(writedata[0]), .frame_start(frame_start), .commit_ok(1'b1),
      .shadow(mix_sh), .active(mix_act), .update(upd[MIX])
`ifdef VIP_CFG_READBACK_EN
      , .pending(pend[MIX])
`endif
   );

   // Timing only goes live once the master has flagged the shadow set valid.
   vip_cfg_bank #(.W($bits(cvo_cfg_t)), .RESET_VAL(CVO_RST)) u_cvo_bank (
      .clk(clk), .reset(reset), .wr_en(wr_accept & hit[CVO]), .wr_value(cvo_new),
      .go(go[CVO]), .go_val(writedata[0]), .frame_start(frame_start), .commit_ok(cvo_valid_q),
      .shadow(cvo_sh), .active(cvo_act), .update(upd[CVO])
`ifdef VIP_CFG_READBACK_EN
      , .pending(pend[CVO])
`endif
   );

`ifdef VIP_CFG_READBACK_EN
   logic [31:0] rmux, rdata_q, rdata_d;
   logic        rvalid_q;

   assign rd_accept = read & ~write & ~wait_q;

   always_comb begin
      rmux = '0;
      case (address)
         ADDR_SCL_GO:    rmux = {31'b0, pend[SCL]};
         ADDR_SCL_W:     rmux = zext12(scl_sh.w);
         ADDR_SCL_H:     rmux = zext12(scl_sh.h);
         ADDR_MIX_GO:    rmux = {31'b0, pend[MIX]};
         ADDR_MIX_BKG_W: rmux = zext12(mix_sh.bkg_w);
         ADDR_MIX_BKG_H: rmux = zext12(mix_sh.bkg_h);
         ADDR_MIX_POS_X: rmux = zext12(mix_sh.pos_x);
         ADDR_MIX_POS_Y: rmux = zext12(mix_sh.pos_y);
         ADDR_MIX_EN:    rmux = {31'b0, mix_sh.en};
         ADDR_CVO_GO:    rmux = {31'b0, pend[CVO]};
         ADDR_CVO_IL:    rmux = {31'b0, cvo_sh.interlaced};
         ADDR_CVO_HACT:  rmux = zext12(cvo_sh.hact);
         ADDR_CVO_VACT:  rmux = zext12(cvo_sh.vact);
         ADDR_CVO_HFP:   rmux = zext12(cvo_sh.hfp);
         ADDR_CVO_HS:    rmux = zext12(cvo_sh.hs);
         ADDR_CVO_HBL:   rmux = zext12(cvo_sh.hbl);
         ADDR_CVO_VFP:   rmux = zext12(cvo_sh.vfp);
         ADDR_CVO_VS:    rmux = zext12(cvo_sh.vs);
         ADDR_CVO_VBL:   rmux = zext12(cvo_sh.vbl);
         ADDR_CVO_VALID: rmux = {31'b0, cvo_valid_q};
         default: ;
      endcase
      rdata_d = rd_accept ? rmux : rdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rd_accept;
      end
   end

   assign readdata      = rdata_q;
   assign readdatavalid = rvalid_q;
`else
   assign rd_accept = 1'b0;
   assign pend      = 3'b000;
`endif

   assign waitrequest    = wait_q;
   assign scl_w          = scl_act.w;
   assign scl_h          = scl_act.h;
   assign mix_bkg_w      = mix_act.bkg_w;
   assign mix_bkg_h      = mix_act.bkg_h;
   assign mix_pos_x      = mix_act.pos_x;
   assign mix_pos_y      = mix_act.pos_y;
   assign mix_en         = mix_act.en;
   assign cvo_hact       = cvo_act.hact;
   assign cvo_vact       = cvo_act.vact;
   assign cvo_hfp        = cvo_act.hfp;
   assign cvo_hs         = cvo_act.hs;
   assign cvo_hbl        = cvo_act.hbl;
   assign cvo_vfp        = cvo_act.vfp;
   assign cvo_vs         = cvo_act.vs;
   assign cvo_vbl        = cvo_act.vbl;
   assign cvo_interlaced = cvo_act.interlaced;
   assign cfg_update     = upd;

endmodule

`default_nettype wire

// File: tb/tb_vip_config_responder.sv
// ============================================================================
// tb_vip_config_responder: directed table-driven bench for vip_config_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vip_config_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  address = '0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic        frame_start = 1'b0;
   logic        waitrequest;
   logic [11:0] scl_w, scl_h, mix_bkg_w, mix_bkg_h, mix_pos_x, mix_pos_y;
   logic        mix_en, cvo_interlaced;
   logic [11:0] cvo_hact, cvo_vact, cvo_hfp, cvo_hs, cvo_hbl, cvo_vfp, cvo_vs, cvo_vbl;
   logic [2:0]  cfg_update;
`ifdef VIP_CFG_READBACK_EN
   logic        read = 1'b0;
   logic [31:0] readdata;
   logic        readdatavalid;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vip_config_responder dut (
      .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
`ifdef VIP_CFG_READBACK_EN
      .read(read), .readdata(readdata), .readdatavalid(readdatavalid),
`endif
      .waitrequest(waitrequest), .frame_start(frame_start),
      .scl_w(scl_w), .scl_h(scl_h),
      .mix_bkg_w(mix_bkg_w), .mix_bkg_h(mix_bkg_h), .mix_pos_x(mix_pos_x),
      .mix_pos_y(mix_pos_y), .mix_en(mix_en),
      .cvo_hact(cvo_hact), .cvo_vact(cvo_vact), .cvo_hfp(cvo_hfp), .cvo_hs(cvo_hs),
      .cvo_hbl(cvo_hbl), .cvo_vfp(cvo_vfp), .cvo_vs(cvo_vs), .cvo_vbl(cvo_vbl),
      .cvo_interlaced(cvo_interlaced), .cfg_update(cfg_update)
   );

   typedef struct {
      bit          frm;
      logic [8:0]  a;
      logic [31:0] d;
      int          e_sclw;
      int          e_mixbw;
      int          e_cvoh;
      int          e_upd;
   } vec_t;

   vec_t vecs[24];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (waitrequest && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (waitrequest) chk("ready_timeout", 1, 0);
   endtask

   task automatic do_write(input logic [8:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a;
      writedata = d;
      write = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 write = 1'b0;
   endtask

   task automatic do_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   function automatic vec_t mkw(input logic [8:0] a, input logic [31:0] d,
                                input int s, input int m, input int c);
      vec_t v;
      v = '{frm: 1'b0, a: a, d: d, e_sclw: s, e_mixbw: m, e_cvoh: c, e_upd: 0};
      return v;
   endfunction

   function automatic vec_t mkf(input int s, input int m, input int c, input int u);
      vec_t v;
      v = '{frm: 1'b1, a: 9'h0, d: 32'h0, e_sclw: s, e_mixbw: m, e_cvoh: c, e_upd: u};
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int k;

      vecs[0]  = mkw(9'h003, 32'd960,       1280, 1280, 1280);
      vecs[1]  = mkw(9'h000, 32'd1,         1280, 1280, 1280);
      vecs[2]  = mkf(                        960, 1280, 1280, 3'b001);
      vecs[3]  = mkw(9'h083, 32'h1234,       960, 1280, 1280);
      vecs[4]  = mkw(9'h1FF, 32'hDEAD,       960, 1280, 1280);
      vecs[5]  = mkw(9'h080, 32'd1,          960, 1280, 1280);
      vecs[6]  = mkf(                        960,  564, 1280, 3'b010);
      vecs[7]  = mkf(                        960,  564, 1280, 3'b000);
      vecs[8]  = mkw(9'h106, 32'd1920,       960,  564, 1280);
      vecs[9]  = mkw(9'h11E, 32'd0,          960,  564, 1280);
      vecs[10] = mkw(9'h100, 32'd1,          960,  564, 1280);
      vecs[11] = mkf(                        960,  564, 1280, 3'b000);
      vecs[12] = mkf(                        960,  564, 1280, 3'b000);
      vecs[13] = mkw(9'h11E, 32'd1,          960,  564, 1280);
      vecs[14] = mkf(                        960,  564, 1920, 3'b100);
      vecs[15] = mkw(9'h003, 32'd640,        960,  564, 1920);
      vecs[16] = mkw(9'h000, 32'd1,          960,  564, 1920);
      vecs[17] = mkw(9'h000, 32'd1,          960,  564, 1920);
      vecs[18] = mkf(                        640,  564, 1920, 3'b001);
      vecs[19] = mkf(                        640,  564, 1920, 3'b000);
      vecs[20] = mkw(9'h080, 32'd1,          640,  564, 1920);
      vecs[21] = mkw(9'h080, 32'd0,          640,  564, 1920);
      vecs[22] = mkw(9'h083, 32'd100,        640,  564, 1920);
      vecs[23] = mkf(                        640,  564, 1920, 3'b000);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_waitreq", waitrequest, 1);
      chk("rst_scl_w", scl_w, 1280);
      chk("rst_scl_h", scl_h, 720);
      chk("rst_mix_bkg_h", mix_bkg_h, 720);
      chk("rst_mix_pos_x", mix_pos_x, 0);
      chk("rst_mix_en", mix_en, 0);
      chk("rst_cvo_hfp", cvo_hfp, 110);
      chk("rst_cvo_hs", cvo_hs, 40);
      chk("rst_cvo_hbl", cvo_hbl, 370);
      chk("rst_cvo_vfp", cvo_vfp, 5);
      chk("rst_cvo_vs", cvo_vs, 5);
      chk("rst_cvo_vbl", cvo_vbl, 30);
      chk("rst_cvo_vact", cvo_vact, 720);
      chk("rst_cvo_il", cvo_interlaced, 0);
      chk("rst_cfg_update", cfg_update, 0);
      reset = 1'b0;
      #1 chk("rel_waitreq_held", waitrequest, 1);
      @(negedge clk);
      chk("rel_waitreq_low", waitrequest, 0);

      // Table-driven main function
      for (int i = 0; i < 24; i++) begin
         if (vecs[i].frm) do_frame();
         else do_write(vecs[i].a, vecs[i].d);
         chk($sformatf("v%0d_scl_w", i), scl_w, vecs[i].e_sclw);
         chk($sformatf("v%0d_mix_bkg_w", i), mix_bkg_w, vecs[i].e_mixbw);
         chk($sformatf("v%0d_cvo_hact", i), cvo_hact, vecs[i].e_cvoh);
         chk($sformatf("v%0d_cfg_update", i), cfg_update, vecs[i].e_upd);
      end
      chk("cvo_vact_kept", cvo_vact, 720);

      // Back-to-back writes: second accept exactly 3 cycles after the first
      @(negedge clk);
      wait_ready();
      address = 9'h084;
      writedata = 32'd300;
      write = 1'b1;
      @(posedge clk);
      #1 address = 9'h089;
      writedata = 32'd77;
      k = 0;
      @(negedge clk);
      while (waitrequest && k < 10) begin
         k++;
         @(negedge clk);
      end
      chk("b2b_stall_cycles", k, 2);
      @(posedge clk);
      #1 write = 1'b0;
      @(negedge clk);
      chk("b2b_stall_after_2nd", waitrequest, 1);

      // Write accepted together with frame_start: commit takes pre-write shadow
      do_write(9'h088, 32'd50);
      do_write(9'h080, 32'd1);
      @(negedge clk);
      wait_ready();
      address = 9'h088;
      writedata = 32'd160;
      write = 1'b1;
      frame_start = 1'b1;
      @(posedge clk);
      #1 write = 1'b0;
      frame_start = 1'b0;
      @(negedge clk);
      chk("sim_pos_x_old", mix_pos_x, 50);
      chk("sim_cfg_update", cfg_update, 3'b010);
      chk("sim_bkg_h", mix_bkg_h, 300);
      chk("sim_pos_y", mix_pos_y, 77);
      chk("sim_bkg_w", mix_bkg_w, 100);
      do_write(9'h08A, 32'd1);
      do_write(9'h080, 32'd1);
      do_frame();
      chk("sim_pos_x_new", mix_pos_x, 160);
      chk("sim_mix_en", mix_en, 1);

      // Asynchronous reset mid-sequence
      do_write(9'h003, 32'd100);
      do_write(9'h000, 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_waitreq", waitrequest, 1);
      chk("mid_rst_scl_w", scl_w, 1280);
      chk("mid_rst_pos_x", mix_pos_x, 0);
      chk("mid_rst_mix_en", mix_en, 0);
      chk("mid_rst_cvo_hact", cvo_hact, 1280);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_frame();
      chk("post_rst_cfg_update", cfg_update, 0);
      chk("post_rst_scl_w", scl_w, 1280);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
